// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared FSM state type and shift-direction encodings
package shift_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/shift_ctrl_shift_step.sv
// shift_step: combinational one-position logical shift (in, dir -> out), zero fill
module shift_step
  import shift_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] in,
  input  logic         dir,
  output logic [W-1:0] out
);
  assign out = (dir == DIR_RIGHT) ? {1'b0, in[W-1:1]} : {in[W-2:0], 1'b0};
endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: round-robin controller sharing one shift stage among NREQ requesters (req_* in, rsp_* out, busy)
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREQ = 2,
  parameter int AW   = $clog2(W) + 1,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*W-1:0]  req_data,
  input  logic [NREQ*AW-1:0] req_amt,
  input  logic [NREQ-1:0]  req_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [IDW-1:0]   rsp_id,
  output logic             busy
);
  state_t state;
  logic [W-1:0] work, nxt;
  logic [AW-1:0] cnt, amt_g, amt_c;
  logic [IDW-1:0] ptr, id, g, c;
  logic dir, hit, acc;
  // First asserted valid at or after ptr+1, wrapping modulo NREQ
  always_comb begin
    g = '0;
    c = '0;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c = IDW'((int'(ptr) + k) % NREQ);
      if (!hit && req_valid[c]) begin
        hit = 1'b1;
        g = c;
      end
    end
  end
  assign req_ready = (!rst && state == IDLE && hit) ? NREQ'(1) << g : '0;
  assign acc = |(req_valid & req_ready);
  assign amt_g = req_amt[g*AW +: AW];
  assign amt_c = (amt_g > AW'(W)) ? AW'(W) : amt_g;
  shift_step #(.W(W)) u_step (.in(work), .dir(dir), .out(nxt));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work <= '0;
      cnt <= '0;
      dir <= DIR_LEFT;
      id <= '0;
      ptr <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: if (acc) begin
          work <= req_data[g*W +: W];
          cnt <= amt_c;
          dir <= req_dir[g];
          id <= g;
          ptr <= g;
          state <= (amt_c != '0) ? SHIFT : DONE;
        end
        SHIFT: begin
          work <= nxt;
          cnt <= cnt - AW'(1);
          state <= (cnt == AW'(1)) ? DONE : SHIFT;
        end
        DONE: state <= rsp_ready ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
  assign rsp_valid = (state == DONE);
  assign rsp_data = work;
  assign rsp_id = id;
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed self-checking bench for shift_ctrl (W=8, NREQ=2)
module tb_shift_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_dir;
  logic [15:0] req_data;
  logic [7:0] req_amt;
  logic rsp_valid, rsp_ready, busy;
  logic [7:0] rsp_data;
  logic [0:0] rsp_id;
  int nchk = 0;
  int nfail = 0;
  shift_ctrl #(.W(8), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );
  always #5 clk = ~clk;
  // Requesters must hold valid and command stable until accepted
  logic [1:0] pv;
  logic [15:0] pd;
  logic [7:0] pa;
  logic [1:0] pr;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (!rst && pv[i])
        assert (req_valid[i] && req_data[i*8 +: 8] == pd[i*8 +: 8] &&
                req_amt[i*4 +: 4] == pa[i*4 +: 4] && req_dir[i] == pr[i])
        else $error("protocol violation: requester %0d changed before accept", i);
    pv <= rst ? 2'b00 : (req_valid & ~req_ready);
    pd <= req_data;
    pa <= req_amt;
    pr <= req_dir;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_accept(input int id, input logic [7:0] d, input logic [3:0] a,
                           input logic dr, output bit ok);
    req_data[id*8 +: 8] = d;
    req_amt[id*4 +: 4] = a;
    req_dir[id] = dr;
    req_valid[id] = 1'b1;
    #1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = req_ready[id];
      step();
    end
    req_valid[id] = 1'b0;
  endtask
  // Edges after the accept edge until rsp_valid is seen
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask
  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    req_data = 16'h0;
    req_amt = 8'h0;
    req_dir = 2'b00;
    rsp_ready = 1'b0;
    step();
    step();
    nchk++;
    if ({rsp_valid, busy, rsp_data, rsp_id} !== 11'b0) begin
      nfail++;
      $display("FAIL reset_outputs: got v=%b busy=%b d=%h id=%h, want all 0", rsp_valid, busy, rsp_data, rsp_id);
    end
    nchk++;
    if (req_ready !== 2'b00) begin
      nfail++;
      $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    req_valid = 2'b00;
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_left();
    bit ok;
    int lat;
    do_accept(0, 8'hB5, 4'd3, 1'b0, ok);
    nchk++;
    if (!ok || busy !== 1'b1) begin
      nfail++;
      $display("FAIL left_accept: ok=%b busy=%b want 1 1", ok, busy);
    end
    wait_rsp(lat);
    nchk++;
    if (lat != 3 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL left_latency: got %0d busy=%b want 3 busy=1", lat, busy);
    end
    nchk++;
    if (rsp_data !== 8'hA8 || rsp_id !== 1'b0) begin
      nfail++;
      $display("FAIL left_result: got %h id %0d want a8 id 0", rsp_data, rsp_id);
    end
    take_rsp();
  endtask
  task automatic test_right();
    bit ok;
    int lat;
    do_accept(1, 8'h81, 4'd7, 1'b1, ok);
    wait_rsp(lat);
    nchk++;
    if (!ok || lat != 7) begin
      nfail++;
      $display("FAIL right_latency: ok=%b got %0d want 7", ok, lat);
    end
    nchk++;
    if (rsp_data !== 8'h01 || rsp_id !== 1'b1) begin
      nfail++;
      $display("FAIL right_result: got %h id %0d want 01 id 1", rsp_data, rsp_id);
    end
    take_rsp();
  endtask
  task automatic test_boundaries();
    bit ok;
    int lat;
    logic [7:0] din [3] = '{8'h3C, 8'hFF, 8'hFF};
    logic [3:0] amt [3] = '{4'd0, 4'd12, 4'd8};
    logic dr [3] = '{1'b0, 1'b0, 1'b1};
    int elat [3] = '{0, 8, 8};
    logic [7:0] eout [3] = '{8'h3C, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      do_accept(0, din[i], amt[i], dr[i], ok);
      wait_rsp(lat);
      nchk++;
      if (!ok || lat != elat[i] || rsp_data !== eout[i] || rsp_id !== 1'b0) begin
        nfail++;
        $display("FAIL boundary_%0d: ok=%b lat=%0d data=%h id=%0d want lat=%0d data=%h id=0",
                 i, ok, lat, rsp_data, rsp_id, elat[i], eout[i]);
      end
      take_rsp();
    end
  endtask
  task automatic test_fairness();
    logic grant [4];
    logic egr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int ng = 0;
    int both = 0;
    rst = 1'b1;
    req_data = 16'h2211;
    req_amt = 8'h11;
    req_dir = 2'b00;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 100 && ng < 4; k++) begin
      if (req_ready == 2'b11) both++;
      if (req_ready != 2'b00) begin
        grant[ng] = req_ready[1];
        ng++;
      end
      step();
    end
    nchk++;
    if (ng != 4 || both != 0) begin
      nfail++;
      $display("FAIL fair_grants: got %0d grants (%0d with ready=11) want 4 (0)", ng, both);
    end
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (i < ng && grant[i] !== egr[i]) begin
        nfail++;
        $display("FAIL fair_order_%0d: got req%0d want req%0d", i, grant[i], egr[i]);
      end
    end
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_backpressure();
    bit ok;
    int lat;
    int bad = 0;
    do_accept(0, 8'h5A, 4'd2, 1'b1, ok);
    wait_rsp(lat);
    req_data[15:8] = 8'hC3;
    req_amt[7:4] = 4'd0;
    req_dir[1] = 1'b0;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h16 || rsp_id !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) bad++;
    end
    nchk++;
    if (!ok || lat != 2 || bad != 0) begin
      nfail++;
      $display("FAIL bp_hold: ok=%b lat=%0d unstable cycles=%0d want lat 2, 0 unstable", ok, lat, bad);
    end
    rsp_ready = 1'b1;
    step();
    nchk++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
      nfail++;
      $display("FAIL bp_single_rsp: valid=%b ready=%b want 0 10", rsp_valid, req_ready);
    end
    step();
    req_valid[1] = 1'b0;
    nchk++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hC3 || rsp_id !== 1'b1) begin
      nfail++;
      $display("FAIL bp_next: valid=%b data=%h id=%0d want 1 c3 1", rsp_valid, rsp_data, rsp_id);
    end
    step();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset_mid();
    bit ok;
    int seen = 0;
    do_accept(0, 8'hF0, 4'd6, 1'b0, ok);
    step();
    step();
    req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    nchk++;
    if (!ok || {rsp_valid, busy, rsp_data, rsp_id} !== 11'b0 || req_ready !== 2'b00) begin
      nfail++;
      $display("FAIL mid_reset: ok=%b v=%b busy=%b d=%h id=%0d ready=%b want all 0",
               ok, rsp_valid, busy, rsp_data, rsp_id, req_ready);
    end
    req_valid = 2'b00;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (rsp_valid || busy) seen++;
    end
    nchk++;
    if (seen != 0) begin
      nfail++;
      $display("FAIL mid_no_rsp: %0d cycles with activity want 0", seen);
    end
    req_valid = 2'b11;
    #1;
    nchk++;
    if (req_ready !== 2'b01) begin
      nfail++;
      $display("FAIL mid_first_grant: got %b want 01", req_ready);
    end
    rst = 1'b1;
    req_valid = 2'b00;
    step();
  endtask
  initial begin
    test_reset();
    test_left();
    test_right();
    test_boundaries();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
